// File: rtl/btn_debounce_tick.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_tick
// Purpose  : Push-button debouncer with one-cycle press tick and auto-repeat.
// Revision : 1.0
// ============================================================================
module btn_debounce_tick #(
  parameter int DB_TICKS     = 200000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic tick,
  output logic db_level
);

  localparam int DW   = $clog2(DB_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_wait1   = 2'd1;
  localparam logic [1:0] c_st_pressed = 2'd2;
  localparam logic [1:0] c_st_wait0   = 2'd3;

  localparam logic [DW-1:0] c_db_last    = DW'(DB_TICKS - 1);
  localparam logic [RW-1:0] c_delay_last = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] c_rate_last  = RW'(REPEAT_RATE - 1);

  logic          r_s1;
  logic          r_s2;
  logic [1:0]    r_state;
  logic [DW-1:0] r_dcnt;
  logic [RW-1:0] r_rcnt;
  logic          r_rpt_armed;

  logic [1:0]    w_state_nxt;
  logic [DW-1:0] w_dcnt_nxt;
  logic [RW-1:0] w_rcnt_nxt;
  logic          w_armed_nxt;
  logic          w_tick_nxt;
  logic [RW-1:0] w_rpt_last;

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_rcnt_nxt  = r_rcnt;
    w_armed_nxt = r_rpt_armed;
    w_tick_nxt  = 1'b0;
    w_rpt_last  = r_rpt_armed ? c_rate_last : c_delay_last;

    case (r_state)
      c_st_idle: begin
        if (r_s2) w_state_nxt = c_st_wait1;
      end
      c_st_wait1: begin
        if (!r_s2) begin
          w_state_nxt = c_st_idle;
        end else if (r_dcnt == c_db_last) begin
          w_state_nxt = c_st_pressed;
          w_tick_nxt  = 1'b1;
          w_rcnt_nxt  = '0;
          w_armed_nxt = 1'b0;
        end else begin
          w_dcnt_nxt = r_dcnt + DW'(1);
        end
      end
      c_st_pressed: begin
        if (!r_s2) begin
          w_state_nxt = c_st_wait0;
        end else if (REPEAT_DELAY != 0) begin
          if (r_rcnt == w_rpt_last) begin
            w_tick_nxt  = 1'b1;
            w_rcnt_nxt  = '0;
            w_armed_nxt = 1'b1;
          end else begin
            w_rcnt_nxt = r_rcnt + RW'(1);
          end
        end
      end
      c_st_wait0: begin
        // Returning to PRESSED keeps the repeat schedule where it was frozen.
        if (r_s2) begin
          w_state_nxt = c_st_pressed;
        end else if (r_dcnt == c_db_last) begin
          w_state_nxt = c_st_idle;
        end else begin
          w_dcnt_nxt = r_dcnt + DW'(1);
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase

    if (w_state_nxt != r_state) w_dcnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_state     <= c_st_idle;
      r_dcnt      <= '0;
      r_rcnt      <= '0;
      r_rpt_armed <= 1'b0;
      tick        <= 1'b0;
      db_level    <= 1'b0;
    end else begin
      r_s1        <= btn;
      r_s2        <= r_s1;
      r_state     <= w_state_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_rpt_armed <= w_armed_nxt;
      tick        <= w_tick_nxt;
      db_level    <= (w_state_nxt == c_st_pressed) || (w_state_nxt == c_st_wait0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_tick.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_tick
// Purpose  : Scoreboard bench for btn_debounce_tick (repeat on / repeat off).
// Revision : 1.0
// ============================================================================
module tb_btn_debounce_tick;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic btn     = 1'b0;
  logic btn_nr  = 1'b0;
  logic tick, db_level, tick_nr, db_level_nr;

  always #5 clk = ~clk;

  btn_debounce_tick #(.DB_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset_n(reset_n), .btn(btn), .tick(tick), .db_level(db_level)
  );

  btn_debounce_tick #(.DB_TICKS(DB), .REPEAT_DELAY(0), .REPEAT_RATE(RR)) dut_nr (
    .clk(clk), .reset_n(reset_n), .btn(btn_nr), .tick(tick_nr), .db_level(db_level_nr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected edge numbers (absolute) of ticks and db_level toggles.
  int q_tick[$];
  int q_lvl[$];
  int q_tick_nr[$];
  int q_lvl_nr[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic prev_lvl    = 1'b0;
  logic prev_lvl_nr = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tick) begin
      if (q_tick.size() == 0) check("tick_unexpected_at_edge", cyc, -1);
      else                    check("tick_edge", cyc, q_tick.pop_front());
    end
    if (db_level != prev_lvl) begin
      if (q_lvl.size() == 0) check("db_level_unexpected_at_edge", cyc, -1);
      else                   check("db_level_edge", cyc, q_lvl.pop_front());
      prev_lvl = db_level;
    end
    if (tick_nr) begin
      if (q_tick_nr.size() == 0) check("nr_tick_unexpected_at_edge", cyc, -1);
      else                       check("nr_tick_edge", cyc, q_tick_nr.pop_front());
    end
    if (db_level_nr != prev_lvl_nr) begin
      if (q_lvl_nr.size() == 0) check("nr_db_level_unexpected_at_edge", cyc, -1);
      else                       check("nr_db_level_edge", cyc, q_lvl_nr.pop_front());
      prev_lvl_nr = db_level_nr;
    end
  end

  // Bit i of pat is the btn value sampled at edge E(base+i).
  task automatic drive(input logic [63:0] pat, input int len, input int rst_at, input bit nr);
    for (int i = 0; i < len; i++) begin
      if (nr) btn_nr = pat[i];
      else    btn    = pat[i];
      reset_n = (i == rst_at) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    btn     = 1'b0;
    btn_nr  = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic finish_scn();
    repeat (4) @(negedge clk);
    check("missing_ticks", q_tick.size(), 0);
    check("missing_db_edges", q_lvl.size(), 0);
    check("nr_missing_ticks", q_tick_nr.size(), 0);
    check("nr_missing_db_edges", q_lvl_nr.size(), 0);
    q_tick.delete();
    q_lvl.delete();
    q_tick_nr.delete();
    q_lvl_nr.delete();
  endtask

  int base;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_tick", int'(tick), 0);
    check("reset_db_level", int'(db_level), 0);
    check("reset_nr_tick", int'(tick_nr), 0);
    check("reset_nr_db_level", int'(db_level_nr), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean short press: tick E6, level E6..E14.
    base = cyc + 1;
    q_tick.push_back(base + 6);
    q_lvl.push_back(base + 6);
    q_lvl.push_back(base + 14);
    drive(64'hFF, 20, -1, 1'b0);
    finish_scn();

    // Held press with auto-repeat.
    base = cyc + 1;
    foreach (q_tick[i]) q_tick.delete(i);
    q_tick.push_back(base + 6);
    q_tick.push_back(base + 16);
    q_tick.push_back(base + 19);
    q_tick.push_back(base + 22);
    q_tick.push_back(base + 25);
    q_tick.push_back(base + 28);
    q_tick.push_back(base + 31);
    q_lvl.push_back(base + 6);
    q_lvl.push_back(base + 36);
    drive(64'h3FFF_FFFF, 40, -1, 1'b0);
    finish_scn();

    // Press bounce: never qualifies.
    base = cyc + 1;
    drive(64'h33, 15, -1, 1'b0);
    finish_scn();

    // Release bounce at E9-E10: repeat schedule slips by three edges.
    base = cyc + 1;
    q_tick.push_back(base + 6);
    q_tick.push_back(base + 19);
    q_tick.push_back(base + 22);
    q_tick.push_back(base + 25);
    q_lvl.push_back(base + 6);
    q_lvl.push_back(base + 31);
    drive(64'h1FF_F9FF, 35, -1, 1'b0);
    finish_scn();

    // Reset at E8 while pressed, button still held: re-debounced from E9.
    base = cyc + 1;
    q_tick.push_back(base + 6);
    q_tick.push_back(base + 15);
    q_lvl.push_back(base + 6);
    q_lvl.push_back(base + 8);
    q_lvl.push_back(base + 15);
    q_lvl.push_back(base + 27);
    drive(64'h1F_FFFF, 40, 8, 1'b0);
    finish_scn();

    // Repeat disabled instance: single tick despite a 40-cycle hold.
    base = cyc + 1;
    q_tick_nr.push_back(base + 6);
    q_lvl_nr.push_back(base + 6);
    q_lvl_nr.push_back(base + 46);
    drive(64'hFF_FFFF_FFFF, 55, -1, 1'b1);
    finish_scn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
